eq_search_unit: RTL and testbench
=================================

// Module: eq_search_unit
//
// PURPOSE
//   Sequencer that time-shares one 32-bit equality comparator to search a small
//   register table for a key. A requester presents a 32-bit key over a val/rdy
//   handshake. The unit scans the table one entry per cycle and returns hit plus
//   the lowest matching index. Used for tag/address match (e.g. store-address
//   check) where one comparator replaces NUM_ENTRIES parallel comparators.
//
// PARAMETERS
//   NUM_ENTRIES  default 8  number of table entries (2..32)
//   IDX_W        derived    $clog2(NUM_ENTRIES), localparam, not overridable
//
// PORTS
//   clk        in   1      clock, rising edge
//   rst_n      in   1      asynchronous reset, active-low
//   wr_en      in   1      write table entry this cycle
//   wr_idx     in   IDX_W  entry written; wr_idx >= NUM_ENTRIES is ignored
//   wr_data    in   32     value written; entry becomes valid
//   clr_all    in   1      invalidate all entries
//   req_val    in   1      search request valid
//   req_rdy    out  1      unit can accept a request
//   req_key    in   32     key to search for
//   resp_val   out  1      result valid
//   resp_rdy   in   1      consumer accepts result
//   resp_hit   out  1      1 = some valid entry equals key
//   resp_idx   out  IDX_W  lowest matching index; 0 on miss
//   busy       out  1      1 in SCAN or RESP
//
// BEHAVIOUR
//   - Reset (rst_n=0, async): state=IDLE, all valid bits=0, entry data=0,
//     resp_val=0, resp_hit=0, resp_idx=0, busy=0. req_rdy=1 once in IDLE.
//   - States:
//     IDLE: req_rdy=1. On req_val: latch key, scan_idx=0, found=0, go to SCAN.
//     SCAN: compare entry[scan_idx] with key; a match counts only if the entry
//       is valid. On the first match, record found=1 and match_idx=scan_idx.
//       scan_idx increments each cycle. Leave SCAN after entry NUM_ENTRIES-1
//       is compared (see CONFIGURATION for early exit). Next state is RESP.
//     RESP: resp_val=1. resp_hit and resp_idx are held stable. When resp_rdy=1,
//       go to IDLE. There is no same-cycle re-accept; req_rdy=0 in RESP.
//   - Latency, full scan: with request accepted at edge E0, resp_val=1 in the
//     cycle after edge E0+NUM_ENTRIES, i.e. NUM_ENTRIES+1 cycles.
//   - Writes are accepted in any state. The table is registered, so a
//     comparison always uses the pre-edge value. If a write targets the entry
//     being compared in the same cycle, that comparison uses the old value.
//     Writes to entries already scanned do not affect the current result.
//   - clr_all takes effect at the edge. Comparisons after that edge see all
//     entries invalid.
//   - wr_en together with clr_all: all entries are cleared, then the written
//     entry is set valid with wr_data (write wins for its entry).
//   - Reset mid-scan or in RESP: the search is aborted and the response is
//     lost. This is not an error.
//   - Duplicate matches: the lowest index wins.
//
// CONFIGURATION
//   EQ_SEARCH_EARLY_EXIT_EN
//     defined:   SCAN exits the cycle a valid match is found. A hit at index k
//                gives resp_val k+2 cycles after the accept edge. A miss still
//                takes NUM_ENTRIES+1 cycles.
//     undefined: the scan always covers all entries, giving a constant latency
//                of NUM_ENTRIES+1 cycles. resp_hit and resp_idx are identical
//                in both builds.
//
// STRUCTURE
//   - eq_search_pkg: typedef enum logic [1:0] {IDLE, SCAN, RESP} eq_search_state_t;
//     localparam WORD_W = 32.
//   - One sub-module: EqComparator_32b_RTL, single instance. in0 = entry
//     [scan_idx], in1 = latched key. Its eq output is ANDed with valid[scan_idx].
//
// TESTING
//   1. Assert rst_n=0 then release -> resp_val=0, busy=0, req_rdy=1;
//      search for 0x0 -> miss (valid bits are 0).
//   2. Write entry i = 0x1000+4*i for i=0..7, search 0x100C -> hit=1, idx=3;
//      latency 9 cycles (full) or 5 cycles (early exit).
//   3. Search 0xDEADBEEF -> hit=0, idx=0, latency 9 in both builds.
//   4. Set entries 2 and 5 to 0xCAFE0000, search 0xCAFE0000 -> idx=2.
//   5. Hold resp_rdy=0 for 3 cycles -> resp_val, hit and idx stable and
//      req_rdy=0; raise resp_rdy -> IDLE next cycle; back-to-back request ok.
//   6. Key is in entry 6; pulse clr_all during scan cycle 2 -> miss.
//      Repeat with rst_n low mid-scan -> IDLE, no resp_val.

Source files
------------

// File: rtl/eq_search_pkg.sv
// Shared types and constants for the eq_search_unit sequential key-match engine.
package eq_search_pkg;
    localparam int WORD_W = 32;
    typedef enum logic [1:0] {IDLE, SCAN, RESP} eq_search_state_t;
endpackage

// File: rtl/eq_search_unit_if.sv
// Table-write port plus request/response handshakes of eq_search_unit.
interface eq_search_unit_if
    import eq_search_pkg::*;
#(
    parameter int NUM_ENTRIES = 8
);
    localparam int IDX_W = $clog2(NUM_ENTRIES);

    logic              wr_en;
    logic [IDX_W-1:0]  wr_idx;
    logic [WORD_W-1:0] wr_data;
    logic              clr_all;
    logic              req_val;
    logic              req_rdy;
    logic [WORD_W-1:0] req_key;
    logic              resp_val;
    logic              resp_rdy;
    logic              resp_hit;
    logic [IDX_W-1:0]  resp_idx;
    logic              busy;

    modport slave (
        input  wr_en, wr_idx, wr_data, clr_all, req_val, req_key, resp_rdy,
        output req_rdy, resp_val, resp_hit, resp_idx, busy
    );
    modport master (
        output wr_en, wr_idx, wr_data, clr_all, req_val, req_key, resp_rdy,
        input  req_rdy, resp_val, resp_hit, resp_idx, busy
    );
endinterface

// File: rtl/eq_search_unit_cmp.sv
// Single shared 32-bit equality comparator used by the search sequencer.
module EqComparator_32b_RTL
    import eq_search_pkg::*;
(
    input  logic [WORD_W-1:0] in0,
    input  logic [WORD_W-1:0] in1,
    output logic              eq
);
    assign eq = (in0 == in1);
endmodule

// File: rtl/eq_search_unit.sv
// Scans a register table one entry per cycle for a key; returns hit and lowest matching index.
// Optional macro EQ_SEARCH_EARLY_EXIT_EN: leave the scan on the first valid match.
module eq_search_unit
    import eq_search_pkg::*;
#(
    parameter int NUM_ENTRIES = 8
) (
    input logic              clk,
    input logic              rst_n,
    eq_search_unit_if.slave  bus
);
    localparam int               IDX_W    = $clog2(NUM_ENTRIES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENTRIES - 1);

    logic [WORD_W-1:0]  data_q [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0] valid_q;

    eq_search_state_t   state_q, state_d;
    logic [WORD_W-1:0]  key_q, key_d;
    logic [IDX_W-1:0]   scan_idx_q, scan_idx_d;
    logic               found_q, found_d;
    logic [IDX_W-1:0]   match_idx_q, match_idx_d;
    logic               cmp_eq;
    logic               match;

    // Write is applied after the clear so the written entry survives a simultaneous clr_all.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < NUM_ENTRIES; i++) data_q[i] <= '0;
        end else begin
            if (bus.clr_all) valid_q <= '0;
            if (bus.wr_en && (int'(bus.wr_idx) < NUM_ENTRIES)) begin
                data_q[bus.wr_idx]  <= bus.wr_data;
                valid_q[bus.wr_idx] <= 1'b1;
            end
        end
    end

    EqComparator_32b_RTL u_cmp (
        .in0 (data_q[scan_idx_q]),
        .in1 (key_q),
        .eq  (cmp_eq)
    );

    assign match = cmp_eq & valid_q[scan_idx_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            key_q       <= '0;
            scan_idx_q  <= '0;
            found_q     <= 1'b0;
            match_idx_q <= '0;
        end else begin
            state_q     <= state_d;
            key_q       <= key_d;
            scan_idx_q  <= scan_idx_d;
            found_q     <= found_d;
            match_idx_q <= match_idx_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        key_d       = key_q;
        scan_idx_d  = scan_idx_q;
        found_d     = found_q;
        match_idx_d = match_idx_q;
        case (state_q)
            IDLE: begin
                if (bus.req_val) begin
                    key_d       = bus.req_key;
                    scan_idx_d  = '0;
                    found_d     = 1'b0;
                    match_idx_d = '0;
                    state_d     = SCAN;
                end
            end
            SCAN: begin
                scan_idx_d = scan_idx_q + 1'b1;
                if (match && !found_q) begin
                    found_d     = 1'b1;
                    match_idx_d = scan_idx_q;
                end
`ifdef EQ_SEARCH_EARLY_EXIT_EN
                if (match || (scan_idx_q == LAST_IDX)) state_d = RESP;
`else
                if (scan_idx_q == LAST_IDX) state_d = RESP;
`endif
            end
            RESP: begin
                if (bus.resp_rdy) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.req_rdy  = (state_q == IDLE);
    assign bus.resp_val = (state_q == RESP);
    assign bus.busy     = (state_q != IDLE);
    assign bus.resp_hit = found_q;
    assign bus.resp_idx = match_idx_q;
endmodule

// File: tb/tb_eq_search_unit.sv
// Randomized + directed bench for eq_search_unit against a lowest-index table-search model.
module tb_eq_search_unit;
  import eq_search_pkg::*;
  localparam int N = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  eq_search_unit_if #(.NUM_ENTRIES(N)) bus ();
  eq_search_unit #(.NUM_ENTRIES(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_chk = 0;
  int n_err = 0;
  logic [31:0] m_data [N];
  logic        m_vld  [N];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Entries above 'limit' are treated as not yet compared (they were cleared before their turn).
  function automatic void model(input logic [31:0] key, input int limit, output logic hit, output int idx);
    hit = 1'b0; idx = 0;
    for (int i = limit; i >= 0; i--)
      if (m_vld[i] && m_data[i] == key) begin hit = 1'b1; idx = i; end
  endfunction

  function automatic int exp_lat(input logic hit, input int idx);
`ifdef EQ_SEARCH_EARLY_EXIT_EN
    return hit ? idx + 2 : N + 1;
`else
    return N + 1;
`endif
  endfunction

  task automatic model_clear();
    for (int i = 0; i < N; i++) m_vld[i] = 1'b0;
  endtask

  task automatic wr(input int idx, input logic [31:0] d, input logic clr);
    @(negedge clk);
    bus.wr_en = 1'b1; bus.wr_idx = 3'(idx); bus.wr_data = d; bus.clr_all = clr;
    @(posedge clk); #1;
    bus.wr_en = 1'b0; bus.clr_all = 1'b0;
    if (clr) model_clear();
    m_data[idx] = d; m_vld[idx] = 1'b1;
  endtask

  task automatic search(input string tag, input logic [31:0] key, input int clr_at, input int hold);
    logic ehit; int eidx; int lat;
    model(key, (clr_at < 0) ? N - 1 : clr_at, ehit, eidx);
    @(negedge clk);
    chk({tag, "_req_rdy_idle"}, 32'(bus.req_rdy), 1);
    bus.req_val = 1'b1; bus.req_key = key;
    @(posedge clk); #1;
    bus.req_val = 1'b0;
    lat = 0;
    for (int n = 0; n < 64; n++) begin
      bus.clr_all = (n == clr_at);
      if (n == clr_at) model_clear();
      @(posedge clk); #1;
      if (bus.resp_val) begin lat = n + 2; break; end
    end
    bus.clr_all = 1'b0;
    chk({tag, "_resp_val"}, 32'(bus.resp_val), 1);
    chk({tag, "_hit"}, 32'(bus.resp_hit), 32'(ehit));
    chk({tag, "_idx"}, 32'(bus.resp_idx), eidx);
    chk({tag, "_lat"}, lat, exp_lat(ehit, eidx));
    chk({tag, "_req_rdy_resp"}, 32'(bus.req_rdy), 0);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk({tag, "_hold_val"}, 32'(bus.resp_val), 1);
      chk({tag, "_hold_hit"}, 32'(bus.resp_hit), 32'(ehit));
      chk({tag, "_hold_idx"}, 32'(bus.resp_idx), eidx);
      chk({tag, "_hold_rdy"}, 32'(bus.req_rdy), 0);
    end
    bus.resp_rdy = 1'b1;
    @(posedge clk); #1;
    bus.resp_rdy = 1'b0;
    chk({tag, "_idle_val"}, 32'(bus.resp_val), 0);
    chk({tag, "_idle_rdy"}, 32'(bus.req_rdy), 1);
    chk({tag, "_idle_busy"}, 32'(bus.busy), 0);
  endtask

  initial begin
    logic [31:0] key;
    int idx;
    bus.wr_en = 0; bus.wr_idx = '0; bus.wr_data = '0; bus.clr_all = 0;
    bus.req_val = 0; bus.req_key = '0; bus.resp_rdy = 0;
    for (int i = 0; i < N; i++) begin m_data[i] = '0; m_vld[i] = 1'b0; end

    // Reset state
    #12;
    chk("rst_resp_val", 32'(bus.resp_val), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_req_rdy", 32'(bus.req_rdy), 1);
    chk("rst_hit", 32'(bus.resp_hit), 0);
    chk("rst_idx", 32'(bus.resp_idx), 0);
    @(negedge clk); rst_n = 1'b1;
    search("empty", 32'h0, -1, 0);

    for (int i = 0; i < N; i++) wr(i, 32'h1000 + 4 * i, 1'b0);
    search("hit3", 32'h100C, -1, 0);
    search("miss", 32'hDEADBEEF, -1, 0);
    search("hit0", 32'h1000, -1, 0);
    search("hit7", 32'h101C, -1, 0);

    wr(2, 32'hCAFE0000, 1'b0);
    wr(5, 32'hCAFE0000, 1'b0);
    search("dup", 32'hCAFE0000, -1, 0);

    // Held response then immediate back-to-back request
    search("hold", 32'h1004, -1, 3);
    search("b2b", 32'h1018, -1, 0);

    // clr_all in scan cycle 2 hides entry 6
    search("clr_mid", 32'h1018, 2, 0);
    search("after_clr", 32'h1000, -1, 0);

    // Simultaneous write and clear: only the written entry remains valid
    for (int i = 0; i < N; i++) wr(i, 32'h2000 + i, 1'b0);
    wr(1, 32'h55, 1'b1);
    search("wrclr_hit", 32'h55, -1, 0);
    search("wrclr_gone", 32'h2003, -1, 0);

    // Reset mid-scan aborts without a response
    wr(6, 32'h77, 1'b0);
    @(negedge clk); bus.req_val = 1'b1; bus.req_key = 32'h77;
    @(posedge clk); #1; bus.req_val = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #2;
    chk("rstmid_busy", 32'(bus.busy), 0);
    chk("rstmid_val", 32'(bus.resp_val), 0);
    chk("rstmid_rdy", 32'(bus.req_rdy), 1);
    model_clear();
    for (int i = 0; i < N; i++) m_data[i] = '0;
    @(negedge clk); rst_n = 1'b1;
    for (int c = 0; c < N + 3; c++) begin
      @(posedge clk); #1;
      chk("rstmid_noresp", 32'(bus.resp_val), 0);
    end
    search("rstmid_clear", 32'h77, -1, 0);

    // Randomized traffic; small value pool forces duplicates
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 2) != 0) begin
        idx = $urandom_range(0, N - 1);
        key = ($urandom_range(0, 1) != 0) ? 32'hA0 + $urandom_range(0, 3) : $urandom;
        wr(idx, key, ($urandom_range(0, 15) == 0));
      end
      case ($urandom_range(0, 2))
        0: key = 32'hA0 + $urandom_range(0, 3);
        1: key = m_data[$urandom_range(0, N - 1)];
        default: key = $urandom;
      endcase
      search("rnd", key, -1, $urandom_range(0, 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
